// File: rtl/alu_cmd_issuer.sv
// Command issuer for a 4-bit combinational ALU: a DEPTH-entry command FIFO
// feeding a single result slot with a valid/ready handshake on each side.
module alu_cmd_issuer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [3:0]                   cmd_a,
   input  logic [3:0]                   cmd_b,
   input  logic [2:0]                   cmd_sel,
   output logic [3:0]                   alu_a,
   output logic [3:0]                   alu_b,
   output logic [2:0]                   alu_sel,
   input  logic [3:0]                   alu_out,
   input  logic                         alu_carry,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [3:0]                   res_data,
   output logic                         res_carry,
   output logic                         res_zero,
   output logic [2:0]                   res_sel,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned PtrW = $clog2(DEPTH);

   if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_depth_check
      $error("alu_cmd_issuer: DEPTH must be 2, 4 or 8");
   end

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] sel;
   } cmd_t;

   typedef enum logic [0:0] {StEmpty, StFull} slot_state_e;

   cmd_t             mem [DEPTH];
   cmd_t             head;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   slot_state_e      state_q, state_d;
   logic             fifo_empty, fifo_full;
   logic             push, issue;
   logic             arith_op;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CntW'(DEPTH));
   assign cmd_ready  = ~fifo_full;
   assign count      = count_q;
   assign head       = mem[rd_ptr_q];

   // Full blocks push even when an issue frees an entry on the same edge.
   assign push  = cmd_valid & ~fifo_full;
   assign issue = ~fifo_empty & ((state_q == StEmpty) | res_ready);

   // Carry is only meaningful for ADD/SUB; other opcodes may leave it stale.
   assign arith_op = (alu_sel[2:1] == 2'b00);

   // FIFO storage; contents are don't-care until written, so no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, sel: cmd_sel};
      end
   end

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (issue) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({push, issue})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ALU operands come straight from the head entry, forced to 0 when empty.
   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_sel = '0;
      if (!fifo_empty) begin
         alu_a   = head.a;
         alu_b   = head.b;
         alu_sel = head.sel;
      end
   end

   // Result slot state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // Result slot next-state: an issue always fills, a lone accept drains.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: if (issue) state_d = StFull;
         StFull:  if (!issue && res_ready) state_d = StEmpty;
         default: state_d = StEmpty;
      endcase
   end

   // Result slot outputs.
   always_comb begin
      res_valid = (state_q == StFull);
   end

   // Result fields load on issue and hold their last value otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data  <= '0;
         res_carry <= 1'b0;
         res_zero  <= 1'b0;
         res_sel   <= '0;
      end else if (issue) begin
         res_data  <= alu_out;
         res_carry <= arith_op & alu_carry;
         res_zero  <= (alu_out == 4'h0);
         res_sel   <= alu_sel;
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural 4-bit ALU and a
// result scoreboard filled on accepted commands and drained on accepted results.
module tb_alu_cmd_issuer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CntW  = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid, cmd_ready;
   logic [3:0]      cmd_a, cmd_b;
   logic [2:0]      cmd_sel;
   logic [3:0]      alu_a, alu_b, alu_out;
   logic [2:0]      alu_sel;
   logic            alu_carry;
   logic            res_valid, res_ready;
   logic [3:0]      res_data;
   logic            res_carry, res_zero;
   logic [2:0]      res_sel;
   logic [CntW-1:0] count;

   int errors = 0;
   int checks = 0;
   logic [8:0] sb[$];  // {sel, carry, zero, data}

   alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
      .res_sel(res_sel), .count(count)
   );

   always #5 clk = ~clk;

   // Returns {carry, out}; carry is 0 for opcodes without one.
   function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] sel);
      logic [4:0] r;
      case (sel)
         3'b000:  r = {1'b0, a} + {1'b0, b};
         3'b001:  r = {(a < b), a - b};
         3'b010:  r = {1'b0, a & b};
         3'b011:  r = {1'b0, a | b};
         3'b100:  r = {1'b0, a ^ b};
         3'b101:  r = {1'b0, ~a};
         3'b110:  r = {1'b0, a << 1};
         default: r = {1'b0, a >> 1};
      endcase
      return r;
   endfunction

   function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel);
      logic [4:0] r;
      r = alu_fn(a, b, sel);
      return {sel, r[4], (r[3:0] == 4'h0), r[3:0]};
   endfunction

   // Behavioural ALU; its carry is stuck at 1 for non-arithmetic opcodes.
   always_comb begin
      logic [4:0] r;
      r         = alu_fn(alu_a, alu_b, alu_sel);
      alu_out   = r[3:0];
      alu_carry = (alu_sel[2:1] == 2'b00) ? r[4] : 1'b1;
   end

   task automatic scoreboard_monitor();
      logic [8:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (res_valid && res_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected: got %03h with no result expected",
                           {res_sel, res_carry, res_zero, res_data});
               end else begin
                  exp = sb.pop_front();
                  if ({res_sel, res_carry, res_zero, res_data} !== exp) begin
                     errors++;
                     $display("FAIL sb_result: got %03h expected %03h",
                              {res_sel, res_carry, res_zero, res_data}, exp);
                  end
               end
            end
            if (cmd_valid && cmd_ready) sb.push_back(model(cmd_a, cmd_b, cmd_sel));
         end
      end
   endtask

   // Offer one command and hold it until accepted (bounded).
   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
      logic acc = 1'b0;
      cmd_valid = 1'b1;
      cmd_a = a;
      cmd_b = b;
      cmd_sel = sel;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got cmd_ready=0 expected acceptance");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      res_ready = 1'b0;
      send(4'h5, 4'h4, 3'b000);
      @(posedge clk);
      #3 rst_n = 1'b0;
      sb.delete();
      #1;
      checks++;
      if ({res_valid, res_data, res_carry, res_zero, res_sel, alu_a, alu_b, alu_sel} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {res_valid, res_data, res_carry, res_zero, res_sel, alu_a, alu_b, alu_sel});
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
      checks++;
      if (count !== '0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", count);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_add();
      res_ready = 1'b1;
      send(4'h9, 4'h8, 3'b000);
      checks++;
      if ({alu_a, alu_b, alu_sel} !== {4'h9, 4'h8, 3'b000} || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_head: got a=%h b=%h sel=%b valid=%b expected 9 8 000 0",
                  alu_a, alu_b, alu_sel, res_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_data, res_carry, res_zero, res_sel} !== {1'b1, 4'h1, 1'b1, 1'b0, 3'b000})
      begin
         errors++;
         $display("FAIL add_result: got v=%b d=%h c=%b z=%b s=%b expected 1 1 1 0 000",
                  res_valid, res_data, res_carry, res_zero, res_sel);
      end
      checks++;
      if (count !== '0 || {alu_a, alu_b, alu_sel} !== '0) begin
         errors++;
         $display("FAIL add_empty_after: got count=%0d alu=%h expected 0 0",
                  count, {alu_a, alu_b, alu_sel});
      end
   endtask

   task automatic test_sub_and_mask();
      res_ready = 1'b1;
      send(4'h3, 4'h5, 3'b001);
      @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_data, res_carry, res_zero} !== {1'b1, 4'hE, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sub_borrow: got v=%b d=%h c=%b z=%b expected 1 e 1 0",
                  res_valid, res_data, res_carry, res_zero);
      end
      send(4'hC, 4'h3, 3'b010);
      @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_data, res_carry, res_zero, res_sel} !== {1'b1, 4'h0, 1'b0, 1'b1, 3'b010})
      begin
         errors++;
         $display("FAIL and_mask: got v=%b d=%h c=%b z=%b s=%b expected 1 0 0 1 010",
                  res_valid, res_data, res_carry, res_zero, res_sel);
      end
      @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b0 || res_data !== 4'h0 || res_sel !== 3'b010) begin
         errors++;
         $display("FAIL drain_hold: got v=%b d=%h s=%b expected 0 0 010",
                  res_valid, res_data, res_sel);
      end
   endtask

   task automatic test_back_pressure();
      res_ready = 1'b0;
      for (int k = 0; k < DEPTH + 1; k++) send(4'(k + 1), 4'(k * 3), 3'(k));
      checks++;
      if (count !== CntW'(DEPTH) || cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_full: got count=%0d ready=%b valid=%b expected %0d 0 1",
                  count, cmd_ready, res_valid, DEPTH);
      end
      cmd_valid = 1'b1;
      cmd_a = 4'hF;
      cmd_b = 4'h1;
      cmd_sel = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (count !== CntW'(DEPTH) || res_data !== 4'h1) begin
         errors++;
         $display("FAIL bp_held: got count=%0d data=%h expected %0d 1", count, res_data, DEPTH);
      end
      res_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         checks++;
         if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_throughput[%0d]: got res_valid=%b expected 1", i, res_valid);
         end
         @(posedge clk);
         #1;
         if (i == 0) begin
            checks++;
            if (count !== CntW'(DEPTH - 1) || cmd_ready !== 1'b1) begin
               errors++;
               $display("FAIL full_boundary: got count=%0d ready=%b expected %0d 1",
                        count, cmd_ready, DEPTH - 1);
            end
         end
         if (i == 1) begin
            cmd_valid = 1'b0;
            checks++;
            if (count !== CntW'(DEPTH - 1)) begin
               errors++;
               $display("FAIL push_after_full: got count=%0d expected %0d", count, DEPTH - 1);
            end
         end
      end
      checks++;
      if (res_valid !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL bp_drained: got valid=%b pending=%0d expected 0 0", res_valid, sb.size());
      end
   endtask

   task automatic test_reset_midstream();
      res_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(4'(k + 7), 4'(k), 3'b011);
      checks++;
      if (count !== CntW'(3) || res_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup: got count=%0d valid=%b expected 3 1", count, res_valid);
      end
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      checks++;
      if (res_valid !== 1'b0 || count !== '0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: got valid=%b count=%0d ready=%b expected 0 0 1",
                  res_valid, count, cmd_ready);
      end
      #1 rst_n = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (res_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL mid_stale[%0d]: got valid=%b count=%0d expected 0 0",
                     i, res_valid, count);
         end
      end
   endtask

   task automatic test_random_stream();
      for (int i = 0; i < 80; i++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_a = 4'($urandom);
         cmd_b = 4'($urandom);
         cmd_sel = 3'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      repeat (DEPTH + 4) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0 || res_valid !== 1'b0 || count !== '0) begin
         errors++;
         $display("FAIL random_drain: got pending=%0d valid=%b count=%0d expected 0 0 0",
                  sb.size(), res_valid, count);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_a = '0;
      cmd_b = '0;
      cmd_sel = '0;
      res_ready = 1'b0;
      fork
         scoreboard_monitor();
      join_none
      test_reset();
      test_add();
      test_sub_and_mask();
      test_back_pressure();
      test_reset_midstream();
      test_random_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, command FIFO entries; legal values 2, 4, 8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cmd_valid  input  1  command offered.
REQ-005 SHALL have port: cmd_ready  output  1  command FIFO can accept.
REQ-006 SHALL have port: cmd_a, cmd_b  input  4 each  operands.
REQ-007 SHALL have port: cmd_sel  input  3  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL, 111 SHR).
REQ-008 SHALL have port: alu_a, alu_b  output  4 each  operands to the 4-bit ALU.
REQ-009 SHALL have port: alu_sel  output  3  opcode to the ALU.
REQ-010 SHALL have port: alu_out  input  4  ALU result, combinational from alu_a/alu_b/alu_sel.
REQ-011 SHALL have port: alu_carry  input  1  ALU carry/borrow; meaningful only for opcodes 000/001.
REQ-012 SHALL have port: res_valid  output  1  result slot holds a result.
REQ-013 SHALL have port: res_ready  input  1  consumer accepts result.
REQ-014 SHALL have port: res_data  output  4  captured result.
REQ-015 SHALL have port: res_carry, res_zero  output  1 each  result flags.
REQ-016 SHALL have port: res_sel  output  3  opcode that produced res_data.
REQ-017 SHALL have port: count  output  clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-018 Push SHALL occur on an edge with cmd_valid && cmd_ready; {cmd_a, cmd_b, cmd_sel} is stored at the tail.
REQ-019 cmd_ready SHALL equal (count != DEPTH); a same-cycle pop SHALL NOT raise cmd_ready when full.
REQ-020 While the FIFO is non-empty, alu_a/alu_b/alu_sel SHALL be driven combinationally from the head entry; while it is empty they SHALL be 0.
REQ-021 The result slot SHALL have two states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-022 Issue SHALL occur on an edge where the FIFO is non-empty && (slot EMPTY || res_ready); issue pops the head and loads alu_out, the masked carry, the zero flag and alu_sel into the slot; the slot goes to or stays FULL.
REQ-023 On an edge where the slot is FULL && res_ready && no issue, the slot SHALL go to EMPTY; the data fields SHALL hold their last values.
REQ-024 The loaded res_carry SHALL be alu_carry for opcodes 000/001 and 0 for all other opcodes (a stale ALU carry is masked).
REQ-025 res_zero SHALL be 1 if and only if the loaded alu_out == 4'h0.
REQ-026 Latency SHALL be 1 cycle: a command pushed at edge N into an empty FIFO, with the slot EMPTY or drained, is issued at edge N+1 and res_valid is high after N+1.
REQ-027 Simultaneous push and issue SHALL leave count unchanged; the FIFO SHALL preserve order; pointers SHALL wrap modulo DEPTH.
REQ-028 Throughput SHALL be 1 result per cycle while res_ready=1 and commands keep arriving.
REQ-029 Total buffering SHALL be DEPTH+1 commands (FIFO plus result slot).

Reset
REQ-030 While rst_n=0 the block SHALL asynchronously clear pointers, count=0, slot EMPTY, res_valid=0, res_data=0, res_carry=0, res_zero=0, res_sel=0, alu_a=alu_b=alu_sel=0, and SHALL hold cmd_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all queued and held commands; no result SHALL be presented after reset deasserts until a new push.

Verification
REQ-032 Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, cmd_ready=1, count=0.
REQ-033 ADD: push A=9, B=8, sel=000, res_ready=1 -> one cycle later res_valid=1, res_data=1, res_carry=1, res_zero=0, res_sel=000.
REQ-034 SUB borrow: push A=3, B=5, sel=001 -> res_data=E, res_carry=1; then AND A=C, B=3 with alu_carry stuck at 1 -> res_data=0, res_zero=1, res_carry=0.
REQ-035 Back-pressure: res_ready=0, offer 6 commands back-to-back -> 5 accepted (1 in the slot, count=4), cmd_ready=0, 6th held; raise res_ready -> 6 results in order, one per cycle.
REQ-036 Full boundary: with count=DEPTH, pulse res_ready for one cycle while cmd_valid=1 -> issue occurs, no push that edge, count=DEPTH-1, then push on the next edge.
REQ-037 Reset mid-stream: 3 queued commands, res_valid=1, pulse rst_n low -> res_valid=0, count=0, no stale results afterwards.
